// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op and FSM state encodings for the iterative mul/div unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [1:0] MUL_OP   = 2'd0;
    localparam logic [1:0] MULHU_OP = 2'd1;
    localparam logic [1:0] DIVU_OP  = 2'd2;
    localparam logic [1:0] REMU_OP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit 1 of the op code selects the divide datapath.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one radix-2 shift-add (multiply) or restoring (divide) step
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W:0]   hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              div_i,
    output logic [DATA_W:0]   hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W:0]   w_r_shift;
    logic [DATA_W:0]   w_x;
    logic [DATA_W:0]   w_y;
    logic [DATA_W+1:0] w_sum;
    logic              w_unused_msb;

    // The top bit of hi/r is always zero between steps (r < b), so it never feeds the adder.
    assign w_unused_msb = hi_i[DATA_W];
    assign w_r_shift    = {hi_i[DATA_W-1:0], lo_i[DATA_W-1]};

    always_comb begin
        w_x = {1'b0, hi_i[DATA_W-1:0]};
        w_y = lo_i[0] ? {1'b0, b_i} : '0;
        if (div_i) begin
            w_x = w_r_shift;
            w_y = ~{1'b0, b_i};
        end
    end

    // Single shared adder; in divide mode the carry-out is the "no borrow" flag.
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(DATA_W+1){1'b0}}, div_i};

    always_comb begin
        hi_o = {1'b0, w_sum[DATA_W:1]};
        lo_o = {w_sum[0], lo_i[DATA_W-1:1]};
        if (div_i) begin
            if (w_sum[DATA_W+1]) begin
                hi_o = w_sum[DATA_W:0];
                lo_o = {lo_i[DATA_W-2:0], 1'b1};
            end else begin
                hi_o = w_r_shift;
                lo_o = {lo_i[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// muldiv_seq : iterative MUL/MULHU/DIVU/REMU unit with valid/ready handshakes
//              Optional zero/trivial-operand shortcut: MULDIV_EARLY_OUT_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_div_by_zero,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W:0]   w_hi_nxt;
    logic [DATA_W-1:0] w_lo_nxt;

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .b_i   (b_q),
        .div_i (op_is_div(op_q)),
        .hi_o  (w_hi_nxt),
        .lo_o  (w_lo_nxt)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            op_q    <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    b_d     = req_b;
                    hi_d    = '0;
                    lo_d    = req_a;
                    cnt_d   = CNT_W'(DATA_W);
                    dbz_d   = op_is_div(req_op) && (req_b == '0);
                    state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    // Preload the registers with the final result so DONE reads them unchanged.
                    if (!op_is_div(req_op) && ((req_a == '0) || (req_b == '0))) begin
                        lo_d    = '0;
                        state_d = DONE;
                    end else if (op_is_div(req_op) && (req_b == '0)) begin
                        hi_d    = {1'b0, req_a};
                        lo_d    = '1;
                        state_d = DONE;
                    end else if (op_is_div(req_op) && (req_a < req_b)) begin
                        hi_d    = {1'b0, req_a};
                        lo_d    = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                hi_d  = w_hi_nxt;
                lo_d  = w_lo_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // op[0] picks the upper register: MULHU -> hi, REMU -> r.
    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign rsp_div_by_zero = rsp_valid && dbz_q;
    assign rsp_result      = !rsp_valid ? '0 :
                             (op_q[0] ? hi_q[DATA_W-1:0] : lo_q);

endmodule

`default_nettype wire
